// File: rtl/reg_writeback_queue.sv
// In-order writeback queue between EX/MEM results and the register-file write port.
// Drains one write per cycle and forwards the newest pending value for rs/rt.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid,
    input  logic [AW-1:0]            ex_rd,
    input  logic [DW-1:0]            ex_data,
    output logic                     ex_ready,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_rd,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    input  logic                     rf_ready,
    input  logic                     flush,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_rd,
    output logic [DW-1:0]            wr_data,
    input  logic [AW-1:0]            rs,
    input  logic [AW-1:0]            rt,
    output logic                     fwd_a_hit,
    output logic [DW-1:0]            fwd_a_data,
    output logic                     fwd_b_hit,
    output logic [DW-1:0]            fwd_b_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    q_rd   [DEPTH];
    logic [DW-1:0]    q_data [DEPTH];
    logic [DEPTH-1:0] q_vld, vld_nxt;
    logic [PW-1:0]    rptr, wptr, ex_ptr;
    logic             mem_push, ex_push, pop;

    // Readiness looks only at the registered count; a pop this cycle frees no slot yet.
    always_comb begin
        mem_ready = (count <= CW'(DEPTH - 1));
        ex_ready  = mem_valid ? (count <= CW'(DEPTH - 2)) : (count <= CW'(DEPTH - 1));
        mem_push  = mem_valid && mem_ready && (mem_rd != '0);
        ex_push   = ex_valid && ex_ready && (ex_rd != '0);
        pop       = (count != '0) && rf_ready;
        ex_ptr    = wptr + PW'(mem_push);
    end

    always_comb begin
        vld_nxt = q_vld;
        if (pop)      vld_nxt[rptr]   = 1'b0;
        if (mem_push) vld_nxt[wptr]   = 1'b1;
        if (ex_push)  vld_nxt[ex_ptr] = 1'b1;
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (mem_push) begin
                q_rd[wptr]   <= mem_rd;
                q_data[wptr] <= mem_data;
            end
            if (ex_push) begin
                q_rd[ex_ptr]   <= ex_rd;
                q_data[ex_ptr] <= ex_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            rptr    <= '0;
            wptr    <= '0;
            q_vld   <= '0;
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else if (flush) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
            q_vld <= '0;
            wr_en <= 1'b0;
        end else begin
            wr_en <= pop;
            if (pop) begin
                wr_rd   <= q_rd[rptr];
                wr_data <= q_data[rptr];
                rptr    <= rptr + 1'b1;
            end
            wptr  <= wptr + PW'(mem_push) + PW'(ex_push);
            count <= count + CW'(mem_push) + CW'(ex_push) - CW'(pop);
            q_vld <= vld_nxt;
        end
    end

    logic [1:0][AW-1:0] raddr;
    logic [1:0]         hit;
    logic [1:0][DW-1:0] hdata;
    logic [PW-1:0]      idx;

    assign raddr = {rt, rs};

    // Walk oldest to newest so later (younger) matches override; the wr_* register is oldest.
    always_comb begin
        hit   = '0;
        hdata = '0;
        idx   = '0;
        for (int p = 0; p < 2; p++) begin
            if (wr_en && wr_rd == raddr[p]) begin
                hit[p]   = 1'b1;
                hdata[p] = wr_data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rptr + PW'(k);
                if (q_vld[idx] && q_rd[idx] == raddr[p]) begin
                    hit[p]   = 1'b1;
                    hdata[p] = q_data[idx];
                end
            end
            if (raddr[p] == '0) begin
                hit[p]   = 1'b0;
                hdata[p] = '0;
            end
        end
    end

    assign fwd_a_hit  = hit[0];
    assign fwd_a_data = hdata[0];
    assign fwd_b_hit  = hit[1];
    assign fwd_b_data = hdata[1];
endmodule
